// File: rtl/equiv_check_sequencer.sv
// Sequences one equivalence run over a golden DUT and its netlist: LFSR stimulus, latency-matched compare, verdict.
// Optional EQC_CAPTURE_EN adds fail_stim/fail_diff capture of the first mismatching vector.
module equiv_check_sequencer #(
    parameter int STIM_W  = 64,
    parameter int Y_W     = 242,
    parameter int DUT_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [STIM_W-1:0] seed,
    input  logic [31:0]       num_vec,
    output logic [STIM_W-1:0] stim,
    input  logic [Y_W-1:0]    y_a,
    input  logic [Y_W-1:0]    y_b,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mism_cnt,
    output logic [31:0]       first_fail
`ifdef EQC_CAPTURE_EN
    ,
    output logic [STIM_W-1:0] fail_stim,
    output logic [Y_W-1:0]    fail_diff
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [63:0]       TAPS64     = 64'hD800_0000_0000_0000;
    localparam logic [STIM_W-1:0] TAPS       = TAPS64[STIM_W-1:0];
    localparam logic [Y_W-1:0]    CMP_MASK   = {{(Y_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]        DRAIN_LAST = 4'(DUT_LAT - 1);
    localparam int                LAST       = DUT_LAT - 1;

    state_t              state_q, state_d;
    logic [STIM_W-1:0]   stim_q, stim_d;
    logic [STIM_W-1:0]   seed_q, seed_d;
    logic [31:0]         num_vec_q, num_vec_d;
    logic [31:0]         vec_idx_q, vec_idx_d;
    logic [3:0]          drain_q, drain_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [CNT_W-1:0]    mism_q, mism_d;
    logic [31:0]         ff_q, ff_d;
    logic [DUT_LAT-1:0]  pv_q, pv_d;
    logic [31:0]         pidx_q [DUT_LAT];
    logic [31:0]         pidx_d [DUT_LAT];
`ifdef EQC_CAPTURE_EN
    logic [STIM_W-1:0]   pstim_q [DUT_LAT];
    logic [STIM_W-1:0]   pstim_d [DUT_LAT];
    logic [STIM_W-1:0]   fail_stim_q, fail_stim_d;
    logic [Y_W-1:0]      fail_diff_q, fail_diff_d;
`endif

    logic                issue_valid;
    logic [31:0]         issue_idx;
    logic [Y_W-1:0]      y_diff;
    logic                mismatch;
    logic                start_ok;

    function automatic logic [STIM_W-1:0] lfsr_next(input logic [STIM_W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    assign y_diff   = (y_a ^ y_b) & CMP_MASK;
    assign mismatch = pv_q[LAST] && (y_diff != '0);
    assign start_ok = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        seed_d      = seed_q;
        num_vec_d   = num_vec_q;
        vec_idx_d   = vec_idx_q;
        drain_d     = drain_q;
        pass_d      = pass_q;
        mism_d      = mism_q;
        ff_d        = ff_q;
        pidx_d      = pidx_q;
        pv_d        = pv_q;
        issue_valid = 1'b0;
        issue_idx   = vec_idx_q;
`ifdef EQC_CAPTURE_EN
        pstim_d     = pstim_q;
        fail_stim_d = fail_stim_q;
        fail_diff_d = fail_diff_q;
`endif

        // Pipe output is the verdict for the vector issued DUT_LAT cycles ago.
        if (mismatch) begin
            if (mism_q != '1) begin
                mism_d = mism_q + CNT_W'(1);
            end
            if (mism_q == '0) begin
                ff_d = pidx_q[LAST];
`ifdef EQC_CAPTURE_EN
                fail_stim_d = pstim_q[LAST];
                fail_diff_d = y_diff;
`endif
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    seed_d    = (seed == '0) ? STIM_W'(1) : seed;
                    num_vec_d = num_vec;
                    mism_d    = '0;
                    ff_d      = '1;
                    pass_d    = 1'b0;
`ifdef EQC_CAPTURE_EN
                    fail_stim_d = '0;
                    fail_diff_d = '0;
`endif
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                stim_d    = seed_q;
                vec_idx_d = 32'd0;
                issue_idx = 32'd0;
                drain_d   = 4'd0;
                if (num_vec_q == 32'd0) begin
                    state_d = S_DONE;
                end else begin
                    issue_valid = 1'b1;
                    state_d     = (num_vec_q == 32'd1) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                stim_d      = lfsr_next(stim_q);
                vec_idx_d   = vec_idx_q + 32'd1;
                issue_valid = 1'b1;
                issue_idx   = vec_idx_d;
                drain_d     = 4'd0;
                if (vec_idx_d == num_vec_q - 32'd1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pv_d[0]   = issue_valid;
        pidx_d[0] = issue_idx;
`ifdef EQC_CAPTURE_EN
        pstim_d[0] = stim_d;
`endif
        for (int i = 1; i < DUT_LAT; i++) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
`ifdef EQC_CAPTURE_EN
            pstim_d[i] = pstim_q[i-1];
`endif
        end

        done_d = (state_d == S_DONE) && (state_q != S_DONE);
        if (done_d) begin
            pass_d = (mism_d == '0);
        end

        // Abort discards the in-flight compare so counters keep their pre-abort values.
        if (abort) begin
            state_d = S_IDLE;
            pv_d    = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            mism_d  = mism_q;
            ff_d    = ff_q;
`ifdef EQC_CAPTURE_EN
            fail_stim_d = fail_stim_q;
            fail_diff_d = fail_diff_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            stim_q    <= '0;
            seed_q    <= STIM_W'(1);
            num_vec_q <= '0;
            vec_idx_q <= '0;
            drain_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            mism_q    <= '0;
            ff_q      <= '1;
            pv_q      <= '0;
            for (int i = 0; i < DUT_LAT; i++) begin
                pidx_q[i] <= '0;
`ifdef EQC_CAPTURE_EN
                pstim_q[i] <= '0;
`endif
            end
`ifdef EQC_CAPTURE_EN
            fail_stim_q <= '0;
            fail_diff_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            stim_q    <= stim_d;
            seed_q    <= seed_d;
            num_vec_q <= num_vec_d;
            vec_idx_q <= vec_idx_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            mism_q    <= mism_d;
            ff_q      <= ff_d;
            pv_q      <= pv_d;
            for (int i = 0; i < DUT_LAT; i++) begin
                pidx_q[i] <= pidx_d[i];
`ifdef EQC_CAPTURE_EN
                pstim_q[i] <= pstim_d[i];
`endif
            end
`ifdef EQC_CAPTURE_EN
            fail_stim_q <= fail_stim_d;
            fail_diff_q <= fail_diff_d;
`endif
        end
    end

    assign stim       = stim_q;
    assign busy       = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = done_q;
    assign pass       = pass_q;
    assign mism_cnt   = mism_q;
    assign first_fail = ff_q;
`ifdef EQC_CAPTURE_EN
    assign fail_stim  = fail_stim_q;
    assign fail_diff  = fail_diff_q;
`endif

endmodule
